pool2x2_window_gen: RTL and testbench

Streaming window generator directly upstream of the 2D max-pooling stage. Accepts one pixel per cycle in raster order and buffers one image row. Emits each non-overlapping 2x2 window (kernel 2, stride 2) as four packed pixels, ready for the pooling reduction. Uses a valid/ready handshake on both sides so pooling back-pressure stalls the pixel stream without loss.

---
 rtl/pool2x2_window_gen.sv | 107 ++++++++++
 tb/tb_pool2x2_window_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_window_gen.sv
// pool2x2_window_gen: buffers one image row and emits each
// non-overlapping 2x2 window of a raster pixel stream.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   valid_in     : input_data valid this cycle
//   in_ready     : block can accept a pixel this cycle
//   input_data   : pixel in raster order
//   valid_out    : window_data holds a complete window
//   out_ready    : downstream accepts the window
//   window_data  : {BR, BL, TR, TL}, TL in the low DATA_W bits
//   out_last     : last window of the frame
module pool2x2_window_gen #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   input_data,
    output logic                valid_out,
    input  logic                out_ready,
    output logic [4*DATA_W-1:0] window_data,
    output logic                out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [DATA_W-1:0]   r_line_buf [IMG_W];
    logic [DATA_W-1:0]   r_bl;
    logic [CW-1:0]       r_col;
    logic [RW-1:0]       r_row;
    logic                r_valid;
    logic                r_last;
    logic [4*DATA_W-1:0] r_window;

    logic          w_accept;
    logic          w_odd_row;
    logic          w_odd_col;
    logic          w_col_end;
    logic          w_row_end;
    logic          w_win;
    logic [CW-1:0] w_col_prev;

    // Any unconsumed window stalls the input, even for pixels that
    // would not complete a window; keeps the handshake trivial.
    assign in_ready   = !(r_valid && !out_ready);
    assign w_accept   = valid_in && in_ready;
    assign w_odd_row  = r_row[0];
    assign w_odd_col  = r_col[0];
    assign w_col_end  = (r_col == COL_MAX);
    assign w_row_end  = (r_row == ROW_MAX);
    assign w_col_prev = r_col - CW'(1);
    assign w_win      = w_accept && w_odd_row && w_odd_col;

    assign valid_out   = r_valid;
    assign window_data = r_window;
    assign out_last    = r_last;

    // Row buffer is never cleared: every entry is rewritten on an
    // even row before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (w_accept && !w_odd_row) begin
            r_line_buf[r_col] <= input_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_bl     <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_window <= '0;
        end else begin
            if (w_accept) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (w_odd_row && !w_odd_col) begin
                    r_bl <= input_data;
                end
            end
            // A load implies in_ready, so the old window is either
            // absent or being consumed this same cycle.
            if (w_win) begin
                r_window <= {input_data, r_bl,
                             r_line_buf[r_col],
                             r_line_buf[w_col_prev]};
                r_valid  <= 1'b1;
                r_last   <= w_row_end && w_col_end;
            end else if (out_ready) begin
                r_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool2x2_window_gen.sv
// tb_pool2x2_window_gen: scoreboard bench for pool2x2_window_gen,
// a 4x4 instance for directed streams and a 16x16 one for random.
module tb_pool2x2_window_gen;

    localparam int DW = 32;

    typedef struct {
        logic [4*DW-1:0] w;
        logic            last;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          valid_in;
    logic          out_ready;
    logic [DW-1:0] din;
    logic          sel;

    logic            vin_a, vin_b, ordy_a, ordy_b;
    logic            irdy_a, irdy_b, vo_a, vo_b;
    logic            last_a, last_b;
    logic [4*DW-1:0] wd_a, wd_b;

    logic            in_ready, vo, last;
    logic [4*DW-1:0] wd;

    assign vin_a    = valid_in && !sel;
    assign vin_b    = valid_in && sel;
    assign ordy_a   = sel ? 1'b1 : out_ready;
    assign ordy_b   = sel ? out_ready : 1'b1;
    assign in_ready = sel ? irdy_b : irdy_a;
    assign vo       = sel ? vo_b : vo_a;
    assign last     = sel ? last_b : last_a;
    assign wd       = sel ? wd_b : wd_a;

    pool2x2_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_a (
        .clk(clk), .rst(rst),
        .valid_in(vin_a), .in_ready(irdy_a),
        .input_data(din),
        .valid_out(vo_a), .out_ready(ordy_a),
        .window_data(wd_a), .out_last(last_a)
    );

    pool2x2_window_gen #(.DATA_W(DW)) u_b (
        .clk(clk), .rst(rst),
        .valid_in(vin_b), .in_ready(irdy_b),
        .input_data(din),
        .valid_out(vo_b), .out_ready(ordy_b),
        .window_data(wd_b), .out_last(last_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wins = 0;
    int lasts = 0;
    int W, H, n;
    logic [DW-1:0] img [16][16];
    exp_t expq[$];
    logic [DW-1:0] px[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [4*DW-1:0] act,
                       input logic [4*DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Reference: place pixel by its frame index; a window is due
    // whenever the pixel lands on an odd row and odd column.
    task automatic model_accept(input logic [DW-1:0] p);
        int r, c;
        exp_t e;
        r = n / W;
        c = n % W;
        img[r][c] = p;
        if (r % 2 == 1 && c % 2 == 1) begin
            e.w = {img[r][c], img[r][c-1],
                   img[r-1][c], img[r-1][c-1]};
            e.last = (r == H - 1 && c == W - 1);
            e.cyc = cyc;
            expq.push_back(e);
        end
        n = (n + 1) % (W * H);
    endtask

    // Monitor: pops on each new window, checks hold stability.
    initial begin
        bit              holding;
        exp_t            e;
        logic [4*DW-1:0] cw;
        logic            cl;
        holding = 0;
        cw = '0;
        cl = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            checks++;
            if (in_ready !== !(vo && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b vo %b ordy %b",
                         in_ready, vo, out_ready);
            end
            if (vo && !holding) begin
                wins++;
                if (last) lasts++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected window: got %h", wd);
                end else begin
                    e = expq.pop_front();
                    if (wd !== e.w || last !== e.last ||
                        cyc != e.cyc + 1) begin
                        errors++;
                        $display("FAIL window: got %h last %b cyc %0d want %h last %b cyc %0d",
                                 wd, last, cyc, e.w, e.last, e.cyc + 1);
                    end
                end
                cw = wd;
                cl = last;
            end else if (vo) begin
                checks++;
                if (wd !== cw || last !== cl) begin
                    errors++;
                    $display("FAIL hold: got %h/%b want %h/%b",
                             wd, last, cw, cl);
                end
            end
            holding = vo && !out_ready;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst valid_out", {127'd0, vo}, '0);
        chk("rst out_last", {127'd0, last}, '0);
        chk("rst window", wd, '0);
        chk("rst in_ready", {127'd0, in_ready}, 128'd1);
        rst = 1'b0;
        n = 0;
    endtask

    // mode 0 full rate, 1 stall on first window, 2 toggle, 3 random
    task automatic stream(input int mode);
        int   i, budget, stall_left;
        bit   started;
        logic tog, v, ordy, acc;
        logic [DW-1:0] d;
        i = 0;
        budget = 0;
        stall_left = 0;
        started = 0;
        tog = 1'b1;
        while (i < px.size()) begin
            @(negedge clk);
            v = 1'b1;
            ordy = 1'b1;
            if (mode == 1 && vo && !started) begin
                started = 1;
                stall_left = 5;
            end
            if (stall_left > 0) ordy = 1'b0;
            if (mode == 2) begin
                v = tog;
                tog = !tog;
            end
            if (mode == 3) begin
                v = ($urandom_range(3) != 0);
                ordy = ($urandom_range(2) != 0);
            end
            d = px[i];
            valid_in = v;
            din = d;
            out_ready = ordy;
            #1;
            acc = v && in_ready;
            if (acc) begin
                model_accept(d);
                i++;
            end
            if (stall_left > 0) begin
                chk("stall no accept", {127'd0, acc}, '0);
                stall_left--;
            end
            budget++;
            if (budget > 4000) begin
                errors++;
                $display("FAIL timeout: accepted %0d of %0d",
                         i, px.size());
                break;
            end
        end
        repeat (4) begin
            @(negedge clk);
            valid_in = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic counts(input string nm, input int w0, input int l0,
                          input int ew, input int el);
        chk({nm, " windows"}, 128'(wins - w0), 128'(ew));
        chk({nm, " lasts"}, 128'(lasts - l0), 128'(el));
        chk({nm, " queue"}, 128'(expq.size()), '0);
    endtask

    initial begin
        int w0, l0;
        rst = 1'b1;
        valid_in = 1'b0;
        out_ready = 1'b1;
        din = '0;
        sel = 1'b0;
        W = 4;
        H = 4;
        n = 0;
        do_reset();

        px.delete();
        for (int k = 0; k < 16; k++) px.push_back(DW'(k));
        w0 = wins; l0 = lasts;
        stream(0);
        counts("full", w0, l0, 4, 1);

        w0 = wins; l0 = lasts;
        stream(1);
        counts("stall", w0, l0, 4, 1);

        w0 = wins; l0 = lasts;
        stream(2);
        counts("toggle", w0, l0, 4, 1);

        px.delete();
        for (int k = 0; k < 16; k++) px.push_back(DW'(k));
        for (int k = 0; k < 16; k++) px.push_back(DW'(100 + k));
        w0 = wins; l0 = lasts;
        stream(0);
        counts("two frames", w0, l0, 8, 2);

        px.delete();
        for (int k = 0; k < 10; k++) px.push_back(DW'(k));
        w0 = wins; l0 = lasts;
        stream(0);
        counts("pre reset", w0, l0, 2, 0);
        do_reset();
        px.delete();
        for (int k = 0; k < 16; k++) px.push_back(DW'(k));
        w0 = wins; l0 = lasts;
        stream(0);
        counts("post reset", w0, l0, 4, 1);

        @(negedge clk);
        sel = 1'b1;
        W = 16;
        H = 16;
        do_reset();
        px.delete();
        for (int k = 0; k < 256; k++) px.push_back($urandom);
        w0 = wins; l0 = lasts;
        stream(3);
        repeat (4) @(negedge clk);
        counts("random", w0, l0, 64, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
